string_sequencer: RTL
=====================

STRING_SEQUENCER -- requirements
Module: string_sequencer

Interface
REQ-001 Parameter STRING_SIZE, default 47: LED data sets per string frame.
REQ-002 Parameter NUMBER_STRINGS, default 47: iteration count wraps at NUMBER_STRINGS-1.
REQ-003 Parameter END_WORDS, default 4: END data sets sent per frame.
REQ-004 Parameter FRAME_GAP, default 1000: idle clocks between frames.
REQ-005 Clocking SHALL be one clock with an asynchronous, active-high reset, ports string_sequencer_clk and string_sequencer_reset.
REQ-006 string_sequencer_clk  in  1  system clock; all logic on rising edge.
REQ-007 string_sequencer_reset  in  1  asynchronous active-high reset.
REQ-008 enable  in  1  frames run back to back while high.
REQ-009 pix_req  out  1  request for the colour of LED pix_index.
REQ-010 pix_index  out  8  LED position 0..STRING_SIZE-1.
REQ-011 pix_iteration  out  8  current iteration 0..NUMBER_STRINGS-1.
REQ-012 pix_valid  in  1  pix_blue/green/red valid, consumed only while pix_req high.
REQ-013 pix_blue, pix_green, pix_red  in  8 each  requester colour.
REQ-014 blue_out, green_out, red_out  out  8 each  data set to doled.
REQ-015 type_out  out  2  0=START, 1=LED, 2=END, to doled type_input.
REQ-016 doled_start  out  1  one-cycle launch pulse to doled.
REQ-017 doled_busy  in  1  doled serialising.
REQ-018 frame_done  out  1  one-cycle pulse after the last END data set completes.

Function
REQ-019 States SHALL be IDLE, GAP, LOAD_START, FETCH, LOAD_LED, LOAD_END, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-020 IDLE: enable=1 -> LOAD_START next cycle; otherwise stay.
REQ-021 LOAD_START: type_out=0, colours 0x00 -> ISSUE.
REQ-022 FETCH: pix_req=1, pix_index=led count; pix_valid=1 -> latch pix colours into colour outputs, drop pix_req same edge -> LOAD_LED.
REQ-023 LOAD_LED: type_out=1 -> ISSUE.
REQ-024 LOAD_END: type_out=2, colours 0xFF -> ISSUE.
REQ-025 ISSUE: doled_busy=0 -> doled_start=1 for exactly one cycle -> WAIT_ACK; doled_busy=1 -> hold, no pulse.
REQ-026 WAIT_ACK: wait for doled_busy=1 -> WAIT_DONE.
REQ-027 WAIT_DONE: on doled_busy=0 pick next: after START -> FETCH (led 0); after LED k<STRING_SIZE-1 -> FETCH k+1; after last LED -> LOAD_END (end count 0); after END j<END_WORDS-1 -> LOAD_END j+1; after last END -> frame_done pulse, iteration update, -> GAP.
REQ-028 GAP: count FRAME_GAP clocks, then LOAD_START if enable=1, else IDLE.
REQ-029 type_out and colour outputs SHALL stay stable from ISSUE until leaving WAIT_DONE.
REQ-030 Iteration SHALL increment by 1 on frame_done and wrap NUMBER_STRINGS-1 -> 0; constant during a frame.
REQ-031 enable falling mid-frame SHALL NOT abort; the frame completes and the block then enters IDLE.
REQ-032 pix_valid outside FETCH SHALL be ignored; pix_valid on the same edge pix_req rises SHALL be accepted.
REQ-033 Counters SHALL be 8 bits; STRING_SIZE and END_WORDS SHALL be 1..255.
REQ-034 No state SHALL issue a second doled_start before doled_busy has risen and fallen.

Reset
REQ-035 Reset asserted SHALL immediately force IDLE; pix_req=0, doled_start=0, frame_done=0, type_out=0, colours 0, pix_index=0, pix_iteration=0, all counters 0.
REQ-036 Reset mid-frame SHALL abandon the frame; after release the next frame starts with START and iteration 0.

Structure
REQ-037 Shared package SHALL hold INPUT_TYPE_START/LED/END, sequencer state encodings, and the default STRING_SIZE/NUMBER_STRINGS.
REQ-038 The gap counter SHALL be one sub-module, string_gap_timer: load, count, done.
REQ-039 doled SHALL be instantiated by the parent, not inside this block.

Verification (STRING_SIZE=3, END_WORDS=2, FRAME_GAP=5, NUMBER_STRINGS=2; doled model busy 4 clocks, 1 clock after start)
REQ-040 Single frame: enable=1, pix_valid 2 clocks after each pix_req -> type sequence 0,1,1,1,2,2; pix_index 0,1,2; exactly 6 doled_start pulses, then one frame_done.
REQ-041 Wrap: three frames -> pix_iteration 0,1,0; frames separated by >=5 idle clocks.
REQ-042 Backpressure: doled_busy held 1 for 20 clocks in ISSUE -> no doled_start until it drops; outputs unchanged throughout.
REQ-043 enable dropped during LED 1 -> frame completes with 6 data sets, then IDLE, no new START.
REQ-044 Reset asserted in WAIT_DONE of LED 2 -> all outputs 0 in the same cycle; after release, next START has pix_iteration=0.
REQ-045 Stray pix_valid pulses in GAP and ISSUE -> no latch; colour outputs unchanged.

Source files
------------

// File: rtl/string_sequencer_pkg.sv
// Shared types and constants for the LED string sequencer.
package string_sequencer_pkg;

    localparam int DEFAULT_STRING_SIZE    = 47;
    localparam int DEFAULT_NUMBER_STRINGS = 47;
    localparam int DEFAULT_END_WORDS      = 4;
    localparam int DEFAULT_FRAME_GAP      = 1000;

    // Data-set type codes presented to doled's type_input.
    localparam logic [1:0] INPUT_TYPE_START = 2'd0;
    localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
    localparam logic [1:0] INPUT_TYPE_END   = 2'd2;

    localparam logic [7:0] COLOUR_OFF  = 8'h00;
    localparam logic [7:0] COLOUR_FULL = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GAP        = 4'd1,
        ST_LOAD_START = 4'd2,
        ST_FETCH      = 4'd3,
        ST_LOAD_LED   = 4'd4,
        ST_LOAD_END   = 4'd5,
        ST_ISSUE      = 4'd6,
        ST_WAIT_ACK   = 4'd7,
        ST_WAIT_DONE  = 4'd8
    } seq_state_t;

    // Increment with wrap back to zero after 'last'.
    function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] last);
        return (value == last) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/string_sequencer_if.sv
// Pixel-requester and doled handshake signals of the string sequencer.
interface string_sequencer_if;
    logic       enable;
    logic       pix_req;
    logic [7:0] pix_index;
    logic [7:0] pix_iteration;
    logic       pix_valid;
    logic [7:0] pix_blue;
    logic [7:0] pix_green;
    logic [7:0] pix_red;
    logic [7:0] blue_out;
    logic [7:0] green_out;
    logic [7:0] red_out;
    logic [1:0] type_out;
    logic       doled_start;
    logic       doled_busy;
    logic       frame_done;

    // Sequencer side.
    modport master (
        input  enable, pix_valid, pix_blue, pix_green, pix_red, doled_busy,
        output pix_req, pix_index, pix_iteration, blue_out, green_out, red_out,
               type_out, doled_start, frame_done
    );

    // Environment side: pixel source and doled.
    modport slave (
        output enable, pix_valid, pix_blue, pix_green, pix_red, doled_busy,
        input  pix_req, pix_index, pix_iteration, blue_out, green_out, red_out,
               type_out, doled_start, frame_done
    );
endinterface

// File: rtl/string_gap_timer.sv
// Inter-frame idle timer: load arms it, count steps it, done pulses once at expiry.
module string_gap_timer
    import string_sequencer_pkg::*;
#(
    parameter int FRAME_GAP = DEFAULT_FRAME_GAP
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);
    localparam int GAP_W = (FRAME_GAP < 2) ? 1 : $clog2(FRAME_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FRAME_GAP);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);

    logic [GAP_W-1:0] remaining_r;
    logic             done_r;

    // Down-counter; done is a single-cycle pulse on the step that reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_r <= GAP_ZERO;
            done_r      <= 1'b0;
        end else if (load) begin
            remaining_r <= GAP_LOAD;
            done_r      <= 1'b0;
        end else if (count && (remaining_r != GAP_ZERO)) begin
            remaining_r <= remaining_r - GAP_ONE;
            done_r      <= (remaining_r == GAP_ONE);
        end else begin
            done_r      <= 1'b0;
        end
    end

    assign done = done_r;
endmodule

// File: rtl/string_sequencer.sv
// Frame sequencer: START, STRING_SIZE LED data sets, END_WORDS END data sets, gap.
module string_sequencer
    import string_sequencer_pkg::*;
#(
    parameter int STRING_SIZE    = DEFAULT_STRING_SIZE,
    parameter int NUMBER_STRINGS = DEFAULT_NUMBER_STRINGS,
    parameter int END_WORDS      = DEFAULT_END_WORDS,
    parameter int FRAME_GAP      = DEFAULT_FRAME_GAP
) (
    input  logic               string_sequencer_clk,
    input  logic               string_sequencer_reset,
    string_sequencer_if.master bus
);
    localparam logic [7:0] LAST_LED  = 8'(STRING_SIZE - 1);
    localparam logic [7:0] LAST_END  = 8'(END_WORDS - 1);
    localparam logic [7:0] LAST_ITER = 8'(NUMBER_STRINGS - 1);

    seq_state_t state_r;
    logic [7:0] led_count_r;
    logic [7:0] end_count_r;
    logic [7:0] iteration_r;
    logic       pix_req_r;
    logic [7:0] blue_r;
    logic [7:0] green_r;
    logic [7:0] red_r;
    logic [1:0] type_r;
    logic       doled_start_r;
    logic       frame_done_r;
    logic       gap_load_r;
    logic       gap_count_s;
    logic       gap_done_s;

    assign gap_count_s = (state_r == ST_GAP);

    string_gap_timer #(.FRAME_GAP(FRAME_GAP)) u_gap_timer (
        .clk   (string_sequencer_clk),
        .rst   (string_sequencer_reset),
        .load  (gap_load_r),
        .count (gap_count_s),
        .done  (gap_done_s)
    );

    // Sequencer FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge string_sequencer_clk or posedge string_sequencer_reset) begin
        if (string_sequencer_reset) begin
            state_r       <= ST_IDLE;
            led_count_r   <= 8'd0;
            end_count_r   <= 8'd0;
            iteration_r   <= 8'd0;
            pix_req_r     <= 1'b0;
            blue_r        <= 8'd0;
            green_r       <= 8'd0;
            red_r         <= 8'd0;
            type_r        <= INPUT_TYPE_START;
            doled_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            gap_load_r    <= 1'b0;
        end else begin
            doled_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            gap_load_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable) state_r <= ST_LOAD_START;
                    else            state_r <= ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_done_s) state_r <= bus.enable ? ST_LOAD_START : ST_IDLE;
                    else            state_r <= ST_GAP;
                end
                ST_LOAD_START: begin
                    type_r  <= INPUT_TYPE_START;
                    blue_r  <= COLOUR_OFF;
                    green_r <= COLOUR_OFF;
                    red_r   <= COLOUR_OFF;
                    state_r <= ST_ISSUE;
                end
                ST_FETCH: begin
                    // pix_req is high for the whole of FETCH, so pix_valid here is always a reply.
                    if (bus.pix_valid) begin
                        blue_r    <= bus.pix_blue;
                        green_r   <= bus.pix_green;
                        red_r     <= bus.pix_red;
                        pix_req_r <= 1'b0;
                        state_r   <= ST_LOAD_LED;
                    end else begin
                        state_r   <= ST_FETCH;
                    end
                end
                ST_LOAD_LED: begin
                    type_r  <= INPUT_TYPE_LED;
                    state_r <= ST_ISSUE;
                end
                ST_LOAD_END: begin
                    type_r  <= INPUT_TYPE_END;
                    blue_r  <= COLOUR_FULL;
                    green_r <= COLOUR_FULL;
                    red_r   <= COLOUR_FULL;
                    state_r <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!bus.doled_busy) begin
                        doled_start_r <= 1'b1;
                        state_r       <= ST_WAIT_ACK;
                    end else begin
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.doled_busy) state_r <= ST_WAIT_DONE;
                    else                state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_DONE: begin
                    if (!bus.doled_busy) begin
                        // type_r still names the data set just completed.
                        case (type_r)
                            INPUT_TYPE_START: begin
                                led_count_r <= 8'd0;
                                pix_req_r   <= 1'b1;
                                state_r     <= ST_FETCH;
                            end
                            INPUT_TYPE_LED: begin
                                if (led_count_r != LAST_LED) begin
                                    led_count_r <= led_count_r + 8'd1;
                                    pix_req_r   <= 1'b1;
                                    state_r     <= ST_FETCH;
                                end else begin
                                    end_count_r <= 8'd0;
                                    state_r     <= ST_LOAD_END;
                                end
                            end
                            INPUT_TYPE_END: begin
                                if (end_count_r != LAST_END) begin
                                    end_count_r <= end_count_r + 8'd1;
                                    state_r     <= ST_LOAD_END;
                                end else begin
                                    frame_done_r <= 1'b1;
                                    iteration_r  <= wrap_inc(iteration_r, LAST_ITER);
                                    gap_load_r   <= 1'b1;
                                    state_r      <= ST_GAP;
                                end
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.pix_req       = pix_req_r;
    assign bus.pix_index     = led_count_r;
    assign bus.pix_iteration = iteration_r;
    assign bus.blue_out      = blue_r;
    assign bus.green_out     = green_r;
    assign bus.red_out       = red_r;
    assign bus.type_out      = type_r;
    assign bus.doled_start   = doled_start_r;
    assign bus.frame_done    = frame_done_r;
endmodule
